// File: rtl/spi_sniffer_sample_extract.sv
// spi_sniffer_sample_extract: passive SPI snooper that extracts one 16-bit sample per CS frame into the clk domain
module spi_sniffer_sample_extract #(
  parameter int SYNC_STAGES   = 2,
  parameter int SKIP_BYTES    = 1,
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter bit SCK_IDLE      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rp2350_sck,
  input  logic        rp2350_cs,
  input  logic        rp2350_miso,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic [7:0]  frames_ok
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SKIP  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [1:0] START = (SKIP_BYTES == 0) ? DATA : SKIP;
  localparam int         WW    = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, miso_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, miso_s;
  logic                   sck_rise, cs_fall, cs_rise;
  logic [WW-1:0]          warm_cnt;
  logic                   ready;
  logic [1:0]             state;
  logic [4:0]             bit_cnt;
  logic [7:0]             byte_cnt;
  logic [15:0]            shreg;
  logic                   last;
  logic [15:0]            assembled;
  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign miso_s    = miso_sync[SYNC_STAGES-1];
  assign sck_rise  = !sck_d && sck_s;
  assign cs_fall   = cs_d && !cs_s;
  assign cs_rise   = !cs_d && cs_s;
  assign ready     = warm_cnt == WW'(SYNC_STAGES + 1);
  assign assembled = LITTLE_ENDIAN ? {shreg[7:0], shreg[15:8]} : shreg;
  // Synchronise the async bus pins; reset to idle levels so release creates no edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      miso_sync <= '0;
      sck_d     <= SCK_IDLE;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], rp2350_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], rp2350_cs};
      miso_sync <= {miso_sync[SYNC_STAGES-2:0], rp2350_miso};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end
  // Ignore CS falls until the chains have flushed, so a reset released mid-frame waits for a new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warm_cnt <= '0;
    else if (!ready) warm_cnt <= warm_cnt + WW'(1);
  end
  // Frame FSM: skip the command bytes, shift in 16 data bits, then ignore burst tail until CS rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      last      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      last      <= 1'b0;
      frame_err <= 1'b0;
      if (cs_fall && ready) begin
        state    <= START;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (cs_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        frame_err <= (state == DATA) || (state == SKIP && (bit_cnt != '0 || byte_cnt != '0));
      end else if (sck_rise && state == SKIP) begin
        bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
        if (bit_cnt == 5'd7) begin
          byte_cnt <= byte_cnt + 8'd1;
          if (byte_cnt == 8'(SKIP_BYTES - 1)) state <= DATA;
        end
      end else if (sck_rise && state == DATA) begin
        shreg   <= {shreg[14:0], miso_s};
        bit_cnt <= bit_cnt + 5'd1;
        if (bit_cnt == 5'd15) begin
          state <= DONE;
          last  <= 1'b1;
        end
      end
    end
  end
  // Publish the completed sample one cycle after the last data bit lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      frames_ok    <= '0;
    end else begin
      sample_valid <= last;
      sample       <= last ? assembled : sample;
      frames_ok    <= last ? frames_ok + 8'd1 : frames_ok;
    end
  end
endmodule
